// File: rtl/dispense_responder.sv
// Dispense-side responder for the vending handshake: stock check, one-hot slot motor
// drive until the drop sensor fires, settle delay, then done / nack / latched jam fault.
module dispense_responder #(
  parameter int NUM_SLOTS    = 7,
  parameter int STOCK_W      = 3,
  parameter int STOCK_INIT   = 4,
  parameter int VEND_TIMEOUT = 50,
  parameter int SETTLE_CYC   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 d,
  input  logic [2:0]           p,
  input  logic                 drop_sense,
  input  logic                 refill,
  input  logic                 fault_clr,
  output logic [NUM_SLOTS-1:0] motor,
  output logic                 busy,
  output logic                 done,
  output logic                 nack,
  output logic                 fault,
  output logic [NUM_SLOTS-1:0] slot_empty
);

  localparam int TIMER_MAX = (VEND_TIMEOUT > SETTLE_CYC) ? VEND_TIMEOUT : SETTLE_CYC;
  localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

  localparam logic [2:0]         MAX_CODE     = 3'(NUM_SLOTS);
  localparam logic [STOCK_W-1:0] STOCK_FULL   = STOCK_W'(STOCK_INIT);
  localparam logic [STOCK_W-1:0] STOCK_ONE    = STOCK_W'(1);
  localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] VEND_LAST    = TIMER_W'(VEND_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LAST  = TIMER_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_VEND,
    S_SETTLE,
    S_DONE,
    S_NACK,
    S_FAULT
  } state_t;

  state_t               state;
  state_t               state_next;
  logic                 d_q;
  logic [2:0]           code;
  logic [TIMER_W-1:0]   timer;
  logic [STOCK_W-1:0]   stock [NUM_SLOTS];

  logic                 request;
  logic [2:0]           slot_idx;
  logic                 code_valid;
  logic                 slot_has_stock;

  // Rising edge of the request level; only acted on from IDLE.
  assign request        = d & ~d_q;
  assign slot_idx       = code - 3'd1;
  assign code_valid     = (code != 3'd0) && (code <= MAX_CODE);
  assign slot_has_stock = code_valid && (stock[slot_idx] != '0);

  // NOTE: every register here is written with <= so all of them update from the
  // same pre-edge values; a blocking = would let later statements see new values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      d_q        <= 1'b0;
      code       <= 3'd0;
      timer      <= '0;
      slot_empty <= '0;
      // NOTE: the stock array is machine state, not bulk storage, so it is reset
      // explicitly; a RAM-style array would normally be left unreset.
      for (int i = 0; i < NUM_SLOTS; i++) begin
        stock[i] <= STOCK_FULL;
      end
    end else begin
      state <= state_next;
      d_q   <= d;

      if (state == S_IDLE && request) begin
        code <= p;
      end

      // Timer restarts on every state change and only runs in the timed states.
      if (state_next != state) begin
        timer <= '0;
      end else if (state == S_VEND || state == S_SETTLE) begin
        timer <= timer + TIMER_ONE;
      end

      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (state == S_IDLE && refill) begin
          stock[i] <= STOCK_FULL;
        end else if (state == S_VEND && drop_sense && slot_idx == 3'(i)) begin
          stock[i] <= stock[i] - STOCK_ONE;
        end
      end

      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_empty[i] <= (stock[i] == '0);
      end
    end
  end

  // NOTE: each output of this block gets a default before the case, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    motor      = '0;
    busy       = (state != S_IDLE);
    done       = 1'b0;
    nack       = 1'b0;
    fault      = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (request) begin
          state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        state_next = slot_has_stock ? S_VEND : S_NACK;
      end
      S_VEND: begin
        motor[slot_idx] = 1'b1;
        // A drop in the final timed cycle still counts as a delivery.
        if (drop_sense) begin
          state_next = S_SETTLE;
        end else if (timer == VEND_LAST) begin
          state_next = S_FAULT;
        end
      end
      S_SETTLE: begin
        if (timer == SETTLE_LAST) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      S_NACK: begin
        nack       = 1'b1;
        state_next = S_IDLE;
      end
      S_FAULT: begin
        fault = 1'b1;
        if (fault_clr) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dispense_responder.sv
// Directed bench for dispense_responder: per-request outcomes are queued from a stock
// model when the request is driven and compared when done/nack/fault appears.
module tb_dispense_responder;

  localparam int NUM_SLOTS    = 6;
  localparam int STOCK_INIT   = 4;
  localparam int VEND_TIMEOUT = 50;
  localparam int SETTLE_CYC   = 4;

  localparam int K_DONE  = 1;
  localparam int K_NACK  = 2;
  localparam int K_FAULT = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 d = 1'b0;
  logic [2:0]           p = 3'd0;
  logic                 drop_sense = 1'b0;
  logic                 refill = 1'b0;
  logic                 fault_clr = 1'b0;
  logic [NUM_SLOTS-1:0] motor;
  logic                 busy;
  logic                 done;
  logic                 nack;
  logic                 fault;
  logic [NUM_SLOTS-1:0] slot_empty;

  typedef struct {
    int                   kind;
    int                   mcycles;
    int                   busy_cyc;
    logic [NUM_SLOTS-1:0] pat;
  } outcome_t;

  outcome_t exp_q[$];
  int       stock_m [NUM_SLOTS];
  int       vectors = 0;
  int       miscompares = 0;

  dispense_responder #(
    .NUM_SLOTS   (NUM_SLOTS),
    .STOCK_W     (3),
    .STOCK_INIT  (STOCK_INIT),
    .VEND_TIMEOUT(VEND_TIMEOUT),
    .SETTLE_CYC  (SETTLE_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .d         (d),
    .p         (p),
    .drop_sense(drop_sense),
    .refill    (refill),
    .fault_clr (fault_clr),
    .motor     (motor),
    .busy      (busy),
    .done      (done),
    .nack      (nack),
    .fault     (fault),
    .slot_empty(slot_empty)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_SLOTS; i++) stock_m[i] = STOCK_INIT;
  endtask

  function automatic logic [NUM_SLOTS-1:0] empty_vec();
    logic [NUM_SLOTS-1:0] v;
    for (int i = 0; i < NUM_SLOTS; i++) v[i] = (stock_m[i] == 0);
    return v;
  endfunction

  // One request: predict the outcome from the stock model, drive it, then watch the DUT.
  task automatic vend(input logic [2:0] code, input int drop_at, input bit hold_d,
                      input bit stray_d, input bit refill_vend, input bit refill_req);
    outcome_t             e;
    outcome_t             o;
    int                   c;
    int                   mc;
    int                   busy_cnt;
    int                   kind;
    bit                   bad;
    logic [NUM_SLOTS-1:0] motor_or;

    c = int'(code);
    if (refill_req) model_reset();
    e.pat     = '0;
    e.mcycles = 0;
    if (c == 0 || c > NUM_SLOTS || stock_m[c-1] == 0) begin
      e.kind     = K_NACK;
      e.busy_cyc = 2;
    end else begin
      e.pat[c-1] = 1'b1;
      if (drop_at == 0) begin
        e.kind     = K_FAULT;
        e.mcycles  = VEND_TIMEOUT;
        e.busy_cyc = 1 + VEND_TIMEOUT + 1;
      end else begin
        e.kind     = K_DONE;
        e.mcycles  = drop_at;
        e.busy_cyc = 1 + drop_at + SETTLE_CYC + 1;
        stock_m[c-1]--;
      end
    end
    exp_q.push_back(e);

    d      = 1'b1;
    p      = code;
    refill = refill_req;
    step();
    refill = 1'b0;
    check("busy_in_check", busy, 1);
    check("motor_in_check", motor, 0);
    if (!hold_d) d = 1'b0;

    mc       = 0;
    busy_cnt = 1;
    kind     = 0;
    bad      = 1'b0;
    motor_or = '0;
    for (int cyc = 0; cyc < 200 && kind == 0; cyc++) begin
      step();
      drop_sense = 1'b0;
      if (busy) busy_cnt++;
      if (motor != '0) begin
        mc++;
        motor_or |= motor;
        if ($countones(motor) != 1) bad = 1'b1;
      end
      if (done) kind = K_DONE;
      else if (nack) kind = K_NACK;
      else if (fault) kind = K_FAULT;
      if (motor != '0 && mc == drop_at) drop_sense = 1'b1;
      if (stray_d && motor != '0 && (mc == 1 || mc == 2)) d = ~d;
      if (refill_vend) refill = (motor != '0 && mc == 1);
    end
    drop_sense = 1'b0;
    refill     = 1'b0;

    o = exp_q.pop_front();
    check("outcome_kind", kind, o.kind);
    check("motor_cycles", mc, o.mcycles);
    check("motor_pattern", motor_or, o.pat);
    check("motor_onehot", bad, 0);
    check("busy_cycles", busy_cnt, o.busy_cyc);
    step();
    if (o.kind == K_FAULT) begin
      check("fault_held", fault, 1);
    end else begin
      check("back_to_idle", busy, 0);
      check("single_pulse", done | nack, 0);
    end
    check("slot_empty", slot_empty, empty_vec());
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    step();
    step();
    check("rst_motor", motor, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_nack", nack, 0);
    check("rst_fault", fault, 0);
    check("rst_slot_empty", slot_empty, 0);
    rst = 1'b0;
    step();

    // Basic vend, drop on third motor cycle.
    vend(3'd3, 3, 0, 0, 0, 0);

    // Drain slot 5, then one more request is rejected.
    for (int i = 0; i < STOCK_INIT; i++) vend(3'd5, 1, 0, 0, 0, 0);
    check("slot5_empty", slot_empty[4], 1);
    vend(3'd5, 1, 0, 0, 0, 0);

    // Invalid codes: below and above the slot range.
    vend(3'd0, 1, 0, 0, 0, 0);
    vend(3'd7, 1, 0, 0, 0, 0);

    // No drop: jam fault after the full timeout; d edges ignored while faulted.
    vend(3'd2, 0, 0, 0, 0, 0);
    d = 1'b1;
    step();
    d = 1'b0;
    step();
    step();
    check("fault_ignores_d", fault, 1);
    check("fault_motor_off", motor, 0);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    check("fault_cleared", fault, 0);
    check("idle_after_clr", busy, 0);

    // d held high across completion with an extra edge inside VEND.
    vend(3'd4, 3, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("held_d_no_retrigger", busy, 0);
    end
    d = 1'b0;
    step();

    // Refill while vending is ignored; slot 5 stays empty.
    vend(3'd1, 2, 0, 0, 1, 0);
    check("refill_in_vend_ignored", slot_empty[4], 1);

    // Refill together with a request on the empty slot: vend proceeds.
    vend(3'd5, 1, 0, 0, 0, 1);

    // Empty slot 6, then reset in the middle of a vend.
    for (int i = 0; i < STOCK_INIT; i++) vend(3'd6, 1, 0, 0, 0, 0);
    check("slot6_empty", slot_empty[5], 1);
    d = 1'b1;
    p = 3'd1;
    step();
    d = 1'b0;
    step();
    check("motor_before_rst", motor, 6'b000001);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    check("motor_after_rst", motor, 0);
    check("busy_after_rst", busy, 0);
    check("slot_empty_after_rst", slot_empty, 0);
    step();

    // Restocked slot 6 vends again.
    vend(3'd6, 1, 0, 0, 0, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
